// File: rtl/aqalu_gen2.sv
`default_nettype none
// ============================================================================
// Module   : aqalu_gen2
// Brief    : Parametrised AQALU with registered result, iterative shift-add
//            multiply and tick-driven seconds-timer / accumulate modes.
// Revision : 1.0 - initial release
// ============================================================================
module aqalu_gen2 #(
    parameter int WIDTH       = 2,
    parameter int OUT_W       = 8,
    parameter int TICK_CYCLES = 10_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Opcode,
    output logic [OUT_W-1:0] Output,
    output logic             busy,
    output logic             done,
    output logic             tick
);
    localparam int c_PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int c_CNT_W   = $clog2(WIDTH + 1);
    localparam int c_PROD_W  = 2 * WIDTH;

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_AND = 4'b0010;
    localparam logic [3:0] c_OP_OR  = 4'b0011;
    localparam logic [3:0] c_OP_XOR = 4'b0100;
    localparam logic [3:0] c_OP_NOT = 4'b0101;
    localparam logic [3:0] c_OP_SHL = 4'b0110;
    localparam logic [3:0] c_OP_SHR = 4'b0111;
    localparam logic [3:0] c_OP_MUL = 4'b1000;
    localparam logic [3:0] c_OP_CMP = 4'b1001;
    localparam logic [3:0] c_OP_ACC = 4'b1110;
    localparam logic [3:0] c_OP_SEC = 4'b1111;

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_RUN  = 1'b1;

    logic [3:0]           r_op_q;
    logic [WIDTH-1:0]     r_a_q, r_b_q;
    logic [0:0]           r_mstate, w_mstate_nxt;
    logic [c_PROD_W-1:0]  r_mcand, w_mcand_nxt;
    logic [c_PROD_W-1:0]  r_mprod, w_mprod_nxt, w_mprod_sum;
    logic [WIDTH-1:0]     r_mplier, w_mplier_nxt;
    logic [c_CNT_W-1:0]   r_mcnt, w_mcnt_nxt;
    logic [c_PRESC_W-1:0] r_presc, w_presc_nxt;
    logic [OUT_W-1:0]     r_out, w_out_nxt;
    logic [OUT_W-1:0]     r_sec, w_sec_nxt;
    logic [OUT_W-1:0]     r_acc, w_acc_nxt;
    logic [OUT_W-1:0]     w_alu;
    logic                 r_done, w_done_nxt, r_tick;
    logic [WIDTH:0]       w_sum, w_diff;
    logic [WIDTH-1:0]     w_nota;
    logic                 w_op_chg, w_ab_chg, w_mul_start, w_wrap, w_enter_timed;

    assign w_op_chg      = (Opcode != r_op_q);
    assign w_ab_chg      = (A != r_a_q) || (B != r_b_q);
    assign w_mul_start   = (Opcode == c_OP_MUL) && (w_op_chg || w_ab_chg);
    assign w_wrap        = (r_presc == c_PRESC_W'(TICK_CYCLES - 1));
    assign w_enter_timed = w_op_chg && ((Opcode == c_OP_SEC) || (Opcode == c_OP_ACC));

    assign w_sum       = {1'b0, A} + {1'b0, B};
    assign w_diff      = {1'b0, A} - {1'b0, B};
    assign w_nota      = ~A;
    assign w_mprod_sum = r_mprod + (r_mplier[0] ? r_mcand : '0);

    // Single-cycle datapath; subtraction is sign-extended from WIDTH+1 bits
    always_comb begin
        w_alu = '0;
        case (Opcode)
            c_OP_ADD: w_alu = OUT_W'(w_sum);
            c_OP_SUB: w_alu = {{(OUT_W - WIDTH - 1){w_diff[WIDTH]}}, w_diff};
            c_OP_AND: w_alu = OUT_W'(A & B);
            c_OP_OR:  w_alu = OUT_W'(A | B);
            c_OP_XOR: w_alu = OUT_W'(A ^ B);
            c_OP_NOT: w_alu = OUT_W'(w_nota);
            c_OP_SHL: w_alu = OUT_W'({A, 1'b0});
            c_OP_SHR: w_alu = OUT_W'(A >> 1);
            c_OP_CMP: w_alu = OUT_W'({(A < B), (A > B), (A == B)});
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        w_mstate_nxt = r_mstate;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_mprod_nxt  = r_mprod;
        w_mcnt_nxt   = r_mcnt;
        w_out_nxt    = r_out;
        w_sec_nxt    = r_sec;
        w_acc_nxt    = r_acc;
        w_done_nxt   = 1'b0;
        w_presc_nxt  = (w_enter_timed || w_wrap) ? '0 : r_presc + c_PRESC_W'(1);

        case (Opcode)
            c_OP_MUL: begin
                if (w_mul_start) begin
                    w_mstate_nxt = c_S_RUN;
                    w_mcand_nxt  = c_PROD_W'(A);
                    w_mplier_nxt = B;
                    w_mprod_nxt  = '0;
                    w_mcnt_nxt   = '0;
                end else if (r_mstate == c_S_RUN) begin
                    w_mcand_nxt  = r_mcand << 1;
                    w_mplier_nxt = r_mplier >> 1;
                    w_mprod_nxt  = w_mprod_sum;
                    w_mcnt_nxt   = r_mcnt + c_CNT_W'(1);
                    if (r_mcnt == c_CNT_W'(WIDTH - 1)) begin
                        w_mstate_nxt = c_S_IDLE;
                        w_done_nxt   = 1'b1;
                        w_out_nxt    = OUT_W'(w_mprod_sum);
                    end
                end
            end
            // Entry clear outranks a coincident tick
            c_OP_SEC: begin
                w_mstate_nxt = c_S_IDLE;
                if (w_op_chg) begin
                    w_sec_nxt = '0;
                    w_out_nxt = '0;
                end else if (w_wrap) begin
                    w_sec_nxt = r_sec + OUT_W'(1);
                    w_out_nxt = r_sec + OUT_W'(1);
                end
            end
            c_OP_ACC: begin
                w_mstate_nxt = c_S_IDLE;
                if (w_op_chg) begin
                    w_acc_nxt = '0;
                    w_out_nxt = '0;
                end else if (w_wrap) begin
                    w_acc_nxt = r_acc + OUT_W'(w_sum);
                    w_out_nxt = r_acc + OUT_W'(w_sum);
                end
            end
            default: begin
                w_mstate_nxt = c_S_IDLE;
                w_out_nxt    = w_alu;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op_q   <= '0;
            r_a_q    <= '0;
            r_b_q    <= '0;
            r_mstate <= c_S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_mprod  <= '0;
            r_mcnt   <= '0;
            r_presc  <= '0;
            r_out    <= '0;
            r_sec    <= '0;
            r_acc    <= '0;
            r_done   <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_op_q   <= Opcode;
            r_a_q    <= A;
            r_b_q    <= B;
            r_mstate <= w_mstate_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_mprod  <= w_mprod_nxt;
            r_mcnt   <= w_mcnt_nxt;
            r_presc  <= w_presc_nxt;
            r_out    <= w_out_nxt;
            r_sec    <= w_sec_nxt;
            r_acc    <= w_acc_nxt;
            r_done   <= w_done_nxt;
            r_tick   <= w_wrap;
        end
    end

    assign Output = r_out;
    assign busy   = (r_mstate == c_S_RUN);
    assign done   = r_done;
    assign tick   = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_aqalu_gen2.sv
`default_nettype none
// ============================================================================
// Module   : tb_aqalu_gen2
// Brief    : Self-checking bench for aqalu_gen2 (WIDTH=4, OUT_W=8, TICK=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aqalu_gen2;
    localparam int W    = 4;
    localparam int OW   = 8;
    localparam int TICK = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [3:0]    Opcode = '0;
    logic [OW-1:0] Output;
    logic          busy, done, tick;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: remaining multiply cycles instead of shift registers
    int m_out = 0, m_done = 0, m_tick = 0, m_presc = 0, m_sec = 0, m_acc = 0;
    int m_mrem = 0, m_ma = 0, m_mb = 0, p_op = 0, p_a = 0, p_b = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[17];

    aqalu_gen2 #(.WIDTH(W), .OUT_W(OW), .TICK_CYCLES(TICK)) dut (
        .clock(clock), .reset(reset), .A(A), .B(B), .Opcode(Opcode),
        .Output(Output), .busy(busy), .done(done), .tick(tick)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            0:       return a + b;
            1:       return (a - b + 256) % 256;
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            5:       return 15 - a;
            6:       return 2 * a;
            7:       return a / 2;
            9:       return (a < b) ? 4 : ((a > b) ? 2 : 1);
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input logic rst, input int a, input int b, input int op);
        int wrap;
        if (rst) begin
            m_out = 0; m_done = 0; m_tick = 0; m_presc = 0; m_sec = 0; m_acc = 0;
            m_mrem = 0; m_ma = 0; m_mb = 0; p_op = 0; p_a = 0; p_b = 0;
            return;
        end
        wrap   = (m_presc == TICK - 1) ? 1 : 0;
        m_tick = wrap;
        m_done = 0;
        if (op == 8) begin
            if (op != p_op || a != p_a || b != p_b) begin
                m_mrem = W; m_ma = a; m_mb = b;
            end else if (m_mrem > 0) begin
                m_mrem--;
                if (m_mrem == 0) begin
                    m_out  = (m_ma * m_mb) % 256;
                    m_done = 1;
                end
            end
        end else begin
            m_mrem = 0;
            if (op == 15) begin
                if (op != p_op) begin m_sec = 0; m_out = 0; end
                else if (wrap == 1) begin m_sec = (m_sec + 1) % 256; m_out = m_sec; end
            end else if (op == 14) begin
                if (op != p_op) begin m_acc = 0; m_out = 0; end
                else if (wrap == 1) begin m_acc = (m_acc + a + b) % 256; m_out = m_acc; end
            end else begin
                m_out = ref_alu(op, a, b);
            end
        end
        if ((op != p_op && op >= 14) || wrap == 1) m_presc = 0;
        else m_presc++;
        p_op = op; p_a = a; p_b = b;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step(reset, int'(A), int'(B), int'(Opcode));
        #1;
        chk("model_out",  32'(Output), 32'(m_out));
        chk("model_busy", 32'(busy),   32'(m_mrem != 0));
        chk("model_done", 32'(done),   32'(m_done));
        chk("model_tick", 32'(tick),   32'(m_tick));
    endtask

    task automatic set_in(input int a, input int b, input int op);
        A = W'(a); B = W'(b); Opcode = 4'(op);
    endtask

    initial begin
        int len;
        vecs[0]  = '{4'd3,  4'd2,  4'h0, 8'h05};
        vecs[1]  = '{4'd2,  4'd3,  4'h1, 8'hFF};
        vecs[2]  = '{4'd5,  4'd9,  4'h9, 8'h04};
        vecs[3]  = '{4'd6,  4'd3,  4'h2, 8'h02};
        vecs[4]  = '{4'd6,  4'd3,  4'h3, 8'h07};
        vecs[5]  = '{4'd6,  4'd3,  4'h4, 8'h05};
        vecs[6]  = '{4'd6,  4'd0,  4'h5, 8'h09};
        vecs[7]  = '{4'd9,  4'd0,  4'h6, 8'h12};
        vecs[8]  = '{4'd9,  4'd0,  4'h7, 8'h04};
        vecs[9]  = '{4'd7,  4'd7,  4'h9, 8'h01};
        vecs[10] = '{4'd9,  4'd5,  4'h9, 8'h02};
        vecs[11] = '{4'd1,  4'd2,  4'hA, 8'h00};
        vecs[12] = '{4'd3,  4'd3,  4'hD, 8'h00};
        vecs[13] = '{4'd15, 4'd15, 4'h0, 8'h1E};
        vecs[14] = '{4'd0,  4'd15, 4'h1, 8'hF1};
        vecs[15] = '{4'd15, 4'd0,  4'h1, 8'h0F};
        vecs[16] = '{4'd15, 4'd0,  4'h6, 8'h1E};

        // Reset held with random inputs
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            cycle();
            chk("rst_out",  32'(Output), 32'd0);
            chk("rst_busy", 32'(busy),   32'd0);
            chk("rst_done", 32'(done),   32'd0);
            chk("rst_tick", 32'(tick),   32'd0);
        end
        reset = 1'b0;

        foreach (vecs[i]) begin
            A = vecs[i].a; B = vecs[i].b; Opcode = vecs[i].op;
            cycle();
            chk("vec_out", 32'(Output), 32'(vecs[i].exp));
        end

        // Multiply 15*15
        set_in(3, 2, 0); cycle();
        set_in(15, 15, 8);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("mul_busy", 32'(busy),   32'd1);
            chk("mul_hold", 32'(Output), 32'd5);
            chk("mul_nodn", 32'(done),   32'd0);
        end
        cycle();
        chk("mul_res",  32'(Output), 32'd225);
        chk("mul_done", 32'(done),   32'd1);
        chk("mul_idle", 32'(busy),   32'd0);
        cycle();
        chk("mul_done1", 32'(done),  32'd0);
        chk("mul_keep",  32'(Output), 32'd225);

        // Restart on mid-run B change
        set_in(15, 15, 0); cycle();
        set_in(15, 15, 8); cycle(); cycle(); cycle();
        set_in(15, 1, 8);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rst_mul_busy", 32'(busy), 32'd1);
            chk("rst_mul_hold", 32'(Output), 32'd30);
        end
        cycle();
        chk("rst_mul_res",  32'(Output), 32'd15);
        chk("rst_mul_done", 32'(done),   32'd1);

        // Abort by leaving 1000 mid-run
        set_in(7, 3, 8); cycle(); cycle();
        set_in(7, 3, 2); cycle();
        chk("abort_busy", 32'(busy),   32'd0);
        chk("abort_out",  32'(Output), 32'd3);
        cycle();
        chk("abort_nodn", 32'(done),   32'd0);

        // Seconds timer
        set_in(1, 1, 15); cycle();
        chk("sec_entry", 32'(Output), 32'd0);
        for (int k = 1; k <= 35; k++) begin
            cycle();
            chk("sec_out", 32'(Output), 32'(k / TICK));
        end
        set_in(1, 2, 0); cycle();
        chk("sec_leave", 32'(Output), 32'd3);
        set_in(1, 2, 15); cycle();
        chk("sec_reentry", 32'(Output), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            cycle();
            chk("sec_out2", 32'(Output), 32'(k / TICK));
        end

        // Accumulate 15+15 per tick
        set_in(15, 15, 14); cycle();
        chk("acc_entry", 32'(Output), 32'd0);
        for (int k = 1; k <= 90; k++) begin
            cycle();
            chk("acc_out", 32'(Output), 32'((30 * (k / TICK)) % 256));
        end
        chk("acc_final", 32'(Output), 32'd14);

        // Reset during multiply RUN
        set_in(1, 1, 0); cycle();
        set_in(7, 3, 8); cycle(); cycle(); cycle();
        reset = 1'b1; cycle();
        chk("rrun_busy", 32'(busy),   32'd0);
        chk("rrun_out",  32'(Output), 32'd0);
        chk("rrun_done", 32'(done),   32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rrun_busy2", 32'(busy), 32'd1);
            chk("rrun_hold",  32'(Output), 32'd0);
        end
        cycle();
        chk("rrun_res",  32'(Output), 32'd21);
        chk("rrun_dn",   32'(done),   32'd1);

        // Randomised segments against the reference model
        for (int s = 0; s < 200; s++) begin
            if ($urandom_range(0, 3) == 0) Opcode = 4'd8;
            else Opcode = 4'($urandom_range(0, 15));
            A = W'($urandom);
            B = W'($urandom);
            reset = ($urandom_range(0, 29) == 0);
            len = int'($urandom_range(1, 24));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) == 0) A = W'($urandom);
                if ($urandom_range(0, 9) == 0) B = W'($urandom);
                cycle();
                reset = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
